// File: rtl/game_pkg.sv
// Shared encodings and constants for the game round controller and its target LFSR.
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_L1    = 3'd1,
    ST_L2    = 3'd2,
    ST_L3    = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } target_t;

  localparam logic [9:0]  HALF_WIDE    = 10'd30;
  localparam logic [9:0]  HALF_NARROW  = 10'd20;
  localparam logic [9:0]  TMO_L1       = 10'd600;
  localparam logic [9:0]  TMO_L2       = 10'd450;
  localparam logic [9:0]  TMO_L3       = 10'd300;
  localparam logic [9:0]  MARGIN       = 10'd60;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Taps 16,14,13,11 as a mask over value[15:0].
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam target_t     TARGET_RST   = '{x: 10'd320, y: 9'd240};

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // x spans 60..571, y spans 60..442 so the target box never leaves the screen.
  function automatic target_t relocate(input logic [15:0] r);
    target_t t;
    t.x = MARGIN + {1'b0, r[8:0]};
    t.y = MARGIN[8:0] + {1'b0, r[15:8]} + {2'b00, r[15:9]};
    return t;
  endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to place targets.
module target_lfsr
  import game_pkg::*;
(
  input  logic        clk_25mHz,
  input  logic        reset,
  output logic [15:0] value
);
  logic fb;

  assign fb = ^(value & LFSR_TAPS);

  always_ff @(posedge clk_25mHz) begin
    if (reset)              value <= LFSR_SEED;
    // All-zero is a lock-up state; reload the seed should it ever appear.
    else if (value == '0)   value <= LFSR_SEED;
    else                    value <= {value[14:0], fb};
  end
endmodule

// File: rtl/game_round_ctrl.sv
// Game round controller: title/level/over sequencing, hold-to-hit scoring, timeouts, target placement.
// Define GAME_LEVEL_RAMP_EN to advance L1->L2->L3 after HITS_PER_LEVEL hits; otherwise play stays in L1.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int HITS_PER_LEVEL = 5,
  parameter int HOLD_FRAMES    = 8
) (
  input  logic        clk_25mHz,
  input  logic        reset,
  input  logic        screen_end,
  input  logic        start_btn,
  input  logic [9:0]  player_x,
  input  logic [8:0]  player_y,
  output logic [31:0] target_x,
  output logic [31:0] target_y,
  output logic [31:0] game_state,
  output logic [31:0] player_lives,
  output logic [15:0] score
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  if (LIVES_INIT < 1 || LIVES_INIT > 9 || HITS_PER_LEVEL < 1 || HOLD_FRAMES < 1) begin : g_bad_cfg
    $error("game_round_ctrl: parameter out of range");
  end

  game_state_e   state_q, state_d;
  logic [3:0]    lives_q, lives_d;
  logic [15:0]   score_q, score_d;
  target_t       tgt_q, tgt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    tmo_q, tmo_d, tmo_lim, half;
  logic          start_q, start_pend_q, start_pend_d, start_evt;
  logic          in_box, hit, miss, reloc;
  logic [15:0]   lfsr;

`ifdef GAME_LEVEL_RAMP_EN
  localparam int LW = $clog2(HITS_PER_LEVEL + 1);
  logic [LW-1:0] lvl_q, lvl_d;
`endif

  target_lfsr u_lfsr (
    .clk_25mHz (clk_25mHz),
    .reset     (reset),
    .value     (lfsr)
  );

  // A press between frames is held until the next screen_end consumes it.
  assign start_evt = start_pend_q | (start_btn & ~start_q);

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    tgt_d        = tgt_q;
    hold_d       = hold_q;
    tmo_d        = tmo_q;
    start_pend_d = start_evt;
    hit          = 1'b0;
    miss         = 1'b0;
    reloc        = 1'b0;
`ifdef GAME_LEVEL_RAMP_EN
    lvl_d        = lvl_q;
`endif
    half    = (state_q == ST_L3) ? HALF_NARROW : HALF_WIDE;
    case (state_q)
      ST_L2:   tmo_lim = TMO_L2;
      ST_L3:   tmo_lim = TMO_L3;
      default: tmo_lim = TMO_L1;
    endcase
    in_box = (abs_diff(player_x, tgt_q.x) < half) &&
             (abs_diff({1'b0, player_y}, {1'b0, tgt_q.y}) < half);

    if (screen_end) begin
      start_pend_d = 1'b0;
      case (state_q)
        ST_TITLE: if (start_evt) begin
          state_d = ST_L1;
          lives_d = 4'(LIVES_INIT);
          score_d = '0;
          reloc   = 1'b1;
`ifdef GAME_LEVEL_RAMP_EN
          lvl_d   = '0;
`endif
        end
        ST_OVER: if (start_evt) state_d = ST_TITLE;
        default: begin
          hold_d = in_box ? hold_q + HW'(1) : '0;
          tmo_d  = tmo_q + 10'd1;
          hit    = in_box && (hold_q == HW'(HOLD_FRAMES - 1));
          miss   = (tmo_q == tmo_lim - 10'd1);
          // A hit wins over a coincident timeout.
          if (hit) begin
            score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            reloc   = 1'b1;
`ifdef GAME_LEVEL_RAMP_EN
            if (state_q != ST_L3) begin
              if (lvl_q == LW'(HITS_PER_LEVEL - 1)) begin
                lvl_d   = '0;
                state_d = (state_q == ST_L1) ? ST_L2 : ST_L3;
              end else begin
                lvl_d   = lvl_q + LW'(1);
              end
            end
`endif
          end else if (miss) begin
            lives_d = lives_q - 4'd1;
            reloc   = 1'b1;
            if (lives_q == 4'd1) state_d = ST_OVER;
          end
        end
      endcase
      if (reloc) begin
        tgt_d  = relocate(lfsr);
        hold_d = '0;
        tmo_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_25mHz) begin
    if (reset) begin
      state_q      <= ST_TITLE;
      lives_q      <= 4'(LIVES_INIT);
      score_q      <= '0;
      tgt_q        <= TARGET_RST;
      hold_q       <= '0;
      tmo_q        <= '0;
      start_q      <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      tgt_q        <= tgt_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      start_q      <= start_btn;
      start_pend_q <= start_pend_d;
    end
  end

`ifdef GAME_LEVEL_RAMP_EN
  always_ff @(posedge clk_25mHz) begin
    if (reset) lvl_q <= '0;
    else       lvl_q <= lvl_d;
  end
`endif

  assign target_x     = 32'(tgt_q.x);
  assign target_y     = 32'(tgt_q.y);
  assign game_state   = 32'(state_q);
  assign player_lives = 32'(lives_q);
  assign score        = score_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed game scenarios plus randomized play against a frame-level model.
module tb_game_round_ctrl;
  localparam int LIVES = 3;
  localparam int HPL   = 5;
  localparam int HOLD  = 8;
`ifdef GAME_LEVEL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, se, start_btn;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [31:0] tx, ty, gs, lives;
  logic [15:0] score;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state (frame-level game rules)
  int          m_state, m_lives, m_score, m_tx, m_ty, m_hold, m_tmo, m_lvl;
  logic [15:0] m_lfsr;
  bit          m_prev, m_pend;

  game_round_ctrl #(.LIVES_INIT(LIVES), .HITS_PER_LEVEL(HPL), .HOLD_FRAMES(HOLD)) dut (
    .clk_25mHz    (clk),
    .reset        (reset),
    .screen_end   (se),
    .start_btn    (start_btn),
    .player_x     (px),
    .player_y     (py),
    .target_x     (tx),
    .target_y     (ty),
    .game_state   (gs),
    .player_lives (lives),
    .score        (score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic model_step();
    bit pn, ev, inb, hit, miss, reloc;
    int h, lim, dx, dy;
    if (reset) begin
      m_state = 0; m_lives = LIVES; m_score = 0; m_tx = 320; m_ty = 240;
      m_hold = 0; m_tmo = 0; m_lvl = 0; m_lfsr = 16'hACE1; m_prev = 0; m_pend = 0;
      return;
    end
    pn = start_btn && !m_prev;
    reloc = 0;
    if (se) begin
      ev = m_pend || pn;
      m_pend = 0;
      if (m_state == 0) begin
        if (ev) begin m_state = 1; m_lives = LIVES; m_score = 0; m_lvl = 0; reloc = 1; end
      end else if (m_state == 4) begin
        if (ev) m_state = 0;
      end else begin
        h   = (m_state == 3) ? 20 : 30;
        lim = (m_state == 1) ? 600 : (m_state == 2) ? 450 : 300;
        dx  = int'(px) - m_tx; if (dx < 0) dx = -dx;
        dy  = int'(py) - m_ty; if (dy < 0) dy = -dy;
        inb = (dx < h) && (dy < h);
        m_hold = inb ? m_hold + 1 : 0;
        m_tmo  = m_tmo + 1;
        hit  = (m_hold >= HOLD);
        miss = (m_tmo >= lim);
        if (hit) begin
          if (m_score < 65535) m_score++;
          reloc = 1;
          if (RAMP && m_state < 3) begin
            m_lvl++;
            if (m_lvl == HPL) begin m_lvl = 0; m_state++; end
          end
        end else if (miss) begin
          m_lives--;
          reloc = 1;
          if (m_lives == 0) m_state = 4;
        end
      end
      if (reloc) begin
        m_tx = 60 + (int'(m_lfsr) % 512);
        m_ty = 60 + (int'(m_lfsr) / 256) + (int'(m_lfsr) / 512);
        m_hold = 0; m_tmo = 0;
      end
    end else if (pn) m_pend = 1;
    m_prev = start_btn;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  always @(posedge clk) model_step();

  task automatic cmp_model();
    chk("m_state", gs, 32'(m_state));
    chk("m_lives", lives, 32'(m_lives));
    chk("m_score", 32'(score), 32'(m_score));
    chk("m_tx", tx, 32'(m_tx));
    chk("m_ty", ty, 32'(m_ty));
  endtask

  // Called at a negedge; one screen_end cycle, check, then two idle cycles.
  task automatic frame();
    se = 1'b1;
    @(negedge clk);
    se = 1'b0;
    cmp_model();
    repeat (2) @(negedge clk);
  endtask

  task automatic hold(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      px = 10'(m_tx + off);
      py = 9'(m_ty);
      frame();
    end
  endtask

  task automatic away(input int n);
    px = '0; py = '0;
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press();
    start_btn = 1'b0; @(negedge clk);
    start_btn = 1'b1; @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, gs, 32'd0);
    chk({tag, "_lives"}, lives, 32'd3);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_tx"}, tx, 32'd320);
    chk({tag, "_ty"}, ty, 32'd240);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dx, dy, gap;
    reset = 1'b1; se = 1'b0; start_btn = 1'b0; px = '0; py = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    press(); @(negedge clk);
    away(1);
    chk("start_state", gs, 32'd1);
    chk("start_lives", lives, 32'd3);
    chk("start_score", 32'(score), 32'd0);
    chk("start_tx_rng", 32'(tx >= 60 && tx <= 571), 32'd1);
    chk("start_ty_rng", 32'(ty >= 60 && ty <= 442), 32'd1);

    hold(7, 0);
    chk("hold7_nohit", 32'(score), 32'd0);
    hold(1, 0);
    chk("hold8_hit", 32'(score), 32'd1);

    px = '0; py = '0;
    press(); frame();
    chk("start_ignored", gs, 32'd1);
    away(598);
    chk("tmo599_lives", lives, 32'd3);
    away(1);
    chk("tmo600_miss", lives, 32'd2);
    away(1200);
    chk("over_state", gs, 32'd4);
    chk("over_lives", lives, 32'd0);
    press(); frame();
    chk("over_to_title", gs, 32'd0);
    press(); frame();
    chk("new_game_state", gs, 32'd1);
    chk("new_game_lives", lives, 32'd3);

    away(592);
    hold(8, 0);
    chk("hit_miss_score", 32'(score), 32'd1);
    chk("hit_miss_lives", lives, 32'd3);

    repeat (3) hold(8, 0);
    hold(8, 25);
    chk("l1_off25_hit", 32'(score), 32'd5);
    chk("to_l2", gs, RAMP ? 32'd2 : 32'd1);
    repeat (5) hold(8, 0);
    chk("to_l3", gs, RAMP ? 32'd3 : 32'd1);
    hold(8, 25);
    chk("l3_off25", 32'(score), RAMP ? 32'd10 : 32'd11);

    // Randomized play: player drifts around the target, start is pressed at random.
    dx = 0; dy = 0;
    for (int f = 0; f < 500; f++) begin
      gap = $urandom_range(1, 5);
      for (int c = 0; c < gap; c++) begin
        start_btn = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) begin
        dx = $urandom_range(0, 70); dx = dx - 35;
        dy = $urandom_range(0, 70); dy = dy - 35;
      end
      px = 10'(m_tx + dx);
      py = 9'(m_ty + dy);
      start_btn = ($urandom_range(0, 15) == 0);
      se = 1'b1;
      @(negedge clk);
      se = 1'b0;
      cmp_model();
    end
    start_btn = 1'b0;

    for (int k = 0; k < 4 && !(m_state inside {1, 2, 3}); k++) begin
      press(); frame();
    end
    px = 10'(m_tx); py = 9'(m_ty);
    se = 1'b1; start_btn = 1'b1; reset = 1'b1;
    @(negedge clk);
    se = 1'b0; start_btn = 1'b0;
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
